// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: serial line, consumer handshake, error and activity signals of the UART receiver
interface uart_rx_framer_if;
  logic       rx;
  logic       rx_ready;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       heard_bit_out;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif
  modport master (
    input  rx, rx_ready, err_clr,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output rx_data, rx_valid, frame_err, overrun, heard_bit_out
  );
  modport slave (
    output rx, rx_ready, err_clr,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  rx_data, rx_valid, frame_err, overrun, heard_bit_out
  );
endinterface

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 UART receiver with one-byte holding register and sticky errors; UART_RX_PARITY_EN adds even parity
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 87,
  localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input logic clk,
  input logic reset,
  uart_rx_framer_if.master bus
);
  localparam logic [CNT_W-1:0] T_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] T_FULL = CNT_W'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic rx_s, tick_half, tick_full, good;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic deliver_q, deliver_d, ferr_set;
  logic [7:0] data_q;
  logic valid_q, ferr_q, ovr_q, heard_q;
`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, perr_set, perr_q;
  assign good = !par_bad_q;
  assign bus.parity_err = perr_q;
`else
  assign good = 1'b1;
`endif
  assign rx_s = sync_q[1];
  assign tick_half = timer_q == T_HALF;
  assign tick_full = timer_q == T_FULL;
  assign bus.rx_data = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun = ovr_q;
  assign bus.heard_bit_out = heard_q;
  // Frame sequencing: next state, bit timer, bit index, shift register and delivery request
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d = idx_q;
    shift_d = shift_q;
    deliver_d = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_set = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = rx_s ? IDLE : START;
        timer_d = '0;
      end
      START: begin
        timer_d = tick_half ? '0 : timer_q + CNT_W'(1);
        idx_d = '0;
        state_d = !tick_half ? START : rx_s ? IDLE : DATA;
      end
      DATA: begin
        timer_d = tick_full ? '0 : timer_q + CNT_W'(1);
        if (tick_full) begin
          shift_d = {rx_s, shift_q[7:1]};
          idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          state_d = (idx_q == 3'd7) ? PARITY : DATA;
`else
          state_d = (idx_q == 3'd7) ? STOP : DATA;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        timer_d = tick_full ? '0 : timer_q + CNT_W'(1);
        if (tick_full) begin
          par_bad_d = rx_s != ^shift_q;
          perr_set = rx_s != ^shift_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        timer_d = tick_full ? '0 : timer_q + CNT_W'(1);
        if (tick_full) begin
          deliver_d = rx_s & good;
          ferr_set = !rx_s;
          state_d = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  // Receiver state register; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      deliver_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      deliver_q <= deliver_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end
  // Line synchroniser, holding register handshake and sticky error flags (a new error beats err_clr)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
      heard_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], bus.rx};
      if (deliver_q && (!valid_q || bus.rx_ready)) begin
        data_q <= shift_q;
        valid_q <= 1'b1;
        heard_q <= ~heard_q;
      end else if (bus.rx_ready) begin
        valid_q <= 1'b0;
      end
      ferr_q <= ferr_set | (ferr_q & ~bus.err_clr);
      ovr_q <= (deliver_q & valid_q & ~bus.rx_ready) | (ovr_q & ~bus.err_clr);
`ifdef UART_RX_PARITY_EN
      perr_q <= perr_set | (perr_q & ~bus.err_clr);
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: scoreboard bench for uart_rx_framer with directed and randomized frames
module tb_uart_rx_framer;
  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 2 + (C - 1) / 2 + 1 + (NB - 1) * C;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int loads = 0;
  int lat = 0;
  bit rand_ready = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] b;
  uart_rx_framer_if bus();
  uart_rx_framer #(.CLKS_PER_BIT(C)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [10:0] frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
    return {stop, par, d, 1'b0};
`else
    return {1'b1, stop, d, 1'b0};
`endif
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx = bits[i];
      repeat (C) begin
        @(posedge clk);
        #1;
        if (rand_ready) bus.rx_ready = ($urandom_range(0, 3) != 0);
      end
    end
    bus.rx = 1'b1;
  endtask
  task automatic send(input logic [7:0] d);
    exp_q.push_back(d);
    loads++;
    drive(frame(d, 1'b1, ^d), NB);
  endtask
  always @(negedge clk) begin
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.rx_data);
      end else begin
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.rx = 1'b1;
    bus.rx_ready = 1'b1;
    bus.err_clr = 1'b0;
    idle(3);
    check("reset_data", {24'd0, bus.rx_data}, 0);
    check("reset_valid", bus.rx_valid, 0);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_heard", bus.heard_bit_out, 0);
    reset = 1'b0;
    idle(2);
    exp_q.push_back(8'hA5);
    loads++;
    fork
      drive(frame(8'hA5, 1'b1, ^8'hA5), NB);
      begin
        lat = 0;
        while (!bus.rx_valid && lat < LAT + 20) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    check("latency_window", (lat >= LAT && lat <= LAT + 2), 1);
    idle(1);
    check("valid_pulse", bus.rx_valid, 0);
    check("heard_a5", bus.heard_bit_out, loads % 2);
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    loads++;
    drive(frame(8'h3C, 1'b1, ^8'h3C), NB);
    drive(frame(8'hC3, 1'b1, ^8'hC3), NB);
    idle(3);
    check("ovr_valid", bus.rx_valid, 1);
    check("ovr_data_kept", {24'd0, bus.rx_data}, 32'h3C);
    check("ovr_flag", bus.overrun, 1);
    check("ovr_heard", bus.heard_bit_out, loads % 2);
    bus.err_clr = 1'b1;
    idle(1);
    bus.err_clr = 1'b0;
    idle(1);
    check("ovr_cleared", bus.overrun, 0);
    bus.rx_ready = 1'b1;
    idle(2);
    check("ovr_drained", bus.rx_valid, 0);
    bus.rx = 1'b0;
    idle(2);
    bus.rx = 1'b1;
    idle(40);
    check("glitch_valid", bus.rx_valid, 0);
    check("glitch_frame_err", bus.frame_err, 0);
    check("glitch_overrun", bus.overrun, 0);
    drive(frame(8'h55, 1'b0, ^8'h55), NB);
    bus.rx = 1'b0;
    idle(40);
    bus.rx = 1'b1;
    idle(5);
    check("brk_frame_err", bus.frame_err, 1);
    check("brk_valid", bus.rx_valid, 0);
    send(8'h12);
    idle(3);
    check("brk_sticky", bus.frame_err, 1);
    check("brk_heard", bus.heard_bit_out, loads % 2);
    bus.err_clr = 1'b1;
    idle(1);
    bus.err_clr = 1'b0;
    idle(1);
    check("brk_cleared", bus.frame_err, 0);
    drive(frame(8'hF0, 1'b1, ^8'hF0), 5);
    bus.rx = 1'b1;
    idle(6);
    reset = 1'b1;
    idle(2);
    check("rst_data", {24'd0, bus.rx_data}, 0);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_heard", bus.heard_bit_out, 0);
    loads = 0;
    reset = 1'b0;
    idle(3);
    send(8'h81);
    idle(5);
    check("rst_heard_after", bus.heard_bit_out, loads % 2);
    check("rst_queue_empty", exp_q.size(), 0);
`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    loads++;
    drive(frame(8'h07, 1'b1, 1'b1), NB);
    drive(frame(8'h07, 1'b1, 1'b0), NB);
    idle(5);
    check("par_err", bus.parity_err, 1);
    check("par_frame_err", bus.frame_err, 0);
    check("par_valid", bus.rx_valid, 0);
    bus.err_clr = 1'b1;
    idle(1);
    bus.err_clr = 1'b0;
    idle(1);
    check("par_cleared", bus.parity_err, 0);
`endif
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      send(b);
      idle($urandom_range(0, 10));
    end
    rand_ready = 1'b0;
    bus.rx_ready = 1'b1;
    idle(10);
    check("rand_overrun", bus.overrun, 0);
    check("rand_frame_err", bus.frame_err, 0);
    check("rand_heard", bus.heard_bit_out, loads % 2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Serial-to-parallel UART receiver, 8N1, feeding received bytes into the RISC_V multi-cycle processor's memory-mapped receive path.
- Sits between the external `rx` pin and the processor's RX data register.
- Runs in the processor clock domain (PLL output).
- Provides a one-byte holding register with a valid/ready handshake, sticky error flags, and the `heard_bit_out` activity indicator driven to the board LED.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per bit period (10 MHz / 115200); legal range >= 4.
- CNT_W, $clog2(CLKS_PER_BIT), bit-timer width; derived, never overridden.

Ports:
- clk  input  1  processor clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- err_clr  input  1  one-cycle pulse clears frame_err and overrun.
- rx_data  output  8  received byte, LSB first on the line.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a byte was dropped because the holding register was full.
- heard_bit_out  output  1  toggles on every byte loaded into rx_data.

Behaviour:
- Clock/reset: one clock, `clk`. `reset` is synchronous and active-high; it is sampled on the `clk` rising edge.
- Values on reset:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, heard_bit_out=0.
  - FSM=IDLE, bit timer=0, bit index=0, shift register=0.
  - Both synchroniser flops=1.
  - Reset mid-frame abandons the partial byte; nothing is delivered.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s, so there is 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rx_s==0 -> START, timer=0.
- START: when timer==(CLKS_PER_BIT-1)/2, sample rx_s.
  - 0 -> DATA, timer=0, index=0.
  - 1 -> IDLE (glitch rejected, no flag).
- DATA: when timer==CLKS_PER_BIT-1, sample rx_s into the shift register MSB, shift right, timer=0, index++. After index 7 is sampled -> STOP.
- STOP: when timer==CLKS_PER_BIT-1, sample rx_s.
  - 1 -> deliver the byte, go to IDLE (mid-stop bit; back-to-back frames are accepted).
  - 0 -> set frame_err, discard the byte, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line therefore yields exactly one frame_err and no bytes.
- Timer: counts up from 0, resets to 0 on each sample point; it does not run in IDLE or BREAK.
- Delivery (registered, 1 cycle after the stop-bit sample):
  - Register empty (rx_valid==0), or rx_valid && rx_ready in the same cycle: load rx_data, set rx_valid=1, toggle heard_bit_out.
  - rx_valid==1 and rx_ready==0: drop the new byte, keep the old rx_data, set overrun; heard_bit_out does not toggle.
- Handshake:
  - rx_valid stays high until rx_ready==1 is sampled with it; rx_valid clears the next cycle unless a simultaneous delivery reloads it.
  - rx_data is stable while rx_valid==1.
  - rx_ready while rx_valid==0 is ignored.
- Errors:
  - err_clr clears both sticky flags.
  - If err_clr coincides with a new error event in the same cycle, the set wins.
- End-to-end latency: from the rx falling edge at the start bit to rx_valid high = 2 + (CLKS_PER_BIT-1)/2 + 1 + 9*CLKS_PER_BIT cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled at timer==CLKS_PER_BIT-1; even parity over the 8 data bits.
  - Adds output port parity_err (1 bit, sticky, reset 0, cleared by err_clr, set wins).
  - On a parity mismatch the byte is discarded at STOP; frame checking is unchanged.
  - Frame length is 11 bits; latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Test Plan:
- CLKS_PER_BIT=8; send 0xA5 8N1, rx_ready held 1 -> rx_valid pulses 1 cycle, rx_data=0xA5 at cycle 2+3+1+72=78 after the start edge; heard_bit_out toggles 0->1.
- Send 0x3C then 0xC3 back-to-back, rx_ready=0 -> rx_data=0x3C kept, overrun=1, heard_bit_out toggled once; pulse err_clr -> overrun=0.
- Low glitch of 2 cycles on rx in idle -> no rx_valid, no flags, FSM back in IDLE.
- Frame 0x55 with the stop bit driven 0, then rx held low 40 cycles, then high -> frame_err=1, no rx_valid; the next frame 0x12 is received correctly.
- Assert reset at the DATA bit-4 sample, release, send 0x81 -> only 0x81 delivered; all outputs 0 during reset.
- UART_RX_PARITY_EN: 0x07 with parity bit 1 -> delivered; 0x07 with parity bit 0 -> parity_err=1, no rx_valid.
